conv_kernel_engine: RTL and testbench
=====================================

Name: conv_kernel_engine

Overview:
- Parametrised successor to the single-pixel 3x3 kernel compute block.
- Computes one output pixel as the weighted sum of a KxK pixel window and a signed coefficient window. K is selectable per operation, 0..MAX_KERNEL.
- Adds signed coefficients, normalisation shift, absolute-value mode for gradient kernels (Sobel), saturation, and a valid/ready result handshake.
- Sits between the window buffer and the blur/gradient stages of the corner-detector pipeline.

Parameters:
- MAX_KERNEL, 5: largest supported window edge.
- PIX_W, 8: pixel width, unsigned.
- COEF_W, 8: coefficient width, two's complement.
- ACC_W, PIX_W+COEF_W+1+$clog2(MAX_KERNEL*MAX_KERNEL): accumulator width, signed. Derived; do not override.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  begin operation; sampled only in IDLE
- clear  in  1  synchronous abort
- kernel_size  in  $clog2(MAX_KERNEL+1)  window edge K
- norm_shift  in  $clog2(ACC_W)  arithmetic right-shift amount
- abs_mode  in  1  take |sum| before saturation
- input_matrix  in  [MAX_KERNEL][MAX_KERNEL][PIX_W]  pixel window, indexed [y][x]
- kernel  in  [MAX_KERNEL][MAX_KERNEL][COEF_W]  signed coefficients, indexed [y][x]
- busy  out  1  high whenever state != IDLE
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result  out  PIX_W  normalised, saturated pixel
- raw_sum  out  ACC_W  signed accumulator value before normalisation
- saturated  out  1  result was clipped

Behaviour:
- Reset (n_rst low at posedge clk):
  - state = IDLE.
  - busy, result_valid, saturated = 0.
  - result, raw_sum = 0.
  - Accumulator and position counters = 0.
- FSM states: IDLE, COMPUTE, NORM, DONE.
- IDLE:
  - On start, snapshot input_matrix, kernel, kernel_size, norm_shift and abs_mode into registers, and zero the accumulator.
  - kernel_size > MAX_KERNEL is clamped to MAX_KERNEL.
  - Go to COMPUTE, or to NORM if K = 0.
- COMPUTE:
  - One MAC per cycle in raster order: y outer, x inner, from (0,0) to (K-1,K-1).
  - Each MAC: acc += signed({1'b0,pixel}) * signed(coef). Full precision; no overflow is possible at ACC_W.
  - After the (K-1,K-1) MAC, go to NORM. COMPUTE lasts exactly K*K cycles.
- NORM (1 cycle):
  - s = acc >>> norm_shift (arithmetic, floor).
  - If abs_mode, s = |s|.
  - result = clamp(s, 0, 2^PIX_W-1). saturated = 1 if clamping changed the value.
  - raw_sum = acc (unshifted).
  - Go to DONE.
- DONE:
  - result_valid = 1. result, raw_sum and saturated are held stable.
  - When result_valid && result_ready, go to IDLE; result_valid deasserts next cycle.
  - result, raw_sum and saturated keep their values until the next NORM.
- Latency: start sampled at cycle 0 gives result_valid at cycle K*K+2. K = 0 gives cycle 2 with result 0.
- start outside IDLE is ignored, including the handshake cycle in DONE. Back-to-back operations need one IDLE cycle.
- Snapshot inputs may change freely once start is accepted.
- clear (any state) takes priority over start and result_ready:
  - next state = IDLE, accumulator = 0, result_valid = 0, busy = 0.
  - result, raw_sum and saturated are unchanged.
- n_rst low mid-operation behaves as reset, at the next clock edge.

Decomposition:
- Package conv_pkg:
  - conv_state_t enum {IDLE, COMPUTE, NORM, DONE}.
  - Function acc_width(pix_w, coef_w, max_k).
  - Function clamp_pix for saturation.
- Sub-module conv_raster_counter: x/y counter with load, enable, programmable K and a last-position flag.
- The MAC and normalisation stay in the top level.

Test Plan:
- 3x3 box blur: K=3, all pixels 9, all coefs 1, shift 0, start at cycle 0 -> result_valid at cycle 11; result=81, raw_sum=81, saturated=0.
- Sobel Gx [-1 0 1; -2 0 2; -1 0 1], left column 10, right column 200:
  - abs_mode=1, shift=2 -> raw_sum=760, result=190.
  - shift=0 -> result=255, saturated=1.
  - Columns swapped, abs_mode=0 -> raw_sum=-760, result=0, saturated=1.
- K=1, pixel[0][0]=100, coef[0][0]=-3, abs_mode=1 -> result_valid at cycle 3, raw_sum=-300, result=255, saturated=1.
- K=0 -> result_valid at cycle 2, result=0. K=7 with MAX_KERNEL=5 -> treated as 5, valid at cycle 27.
- Full 5x5, all pixels 255, all coefs 127 -> raw_sum=809625 with no wrap; shift 12 -> result=197.
- Hold result_ready=0 for 5 cycles in DONE -> outputs stable, start pulses ignored. Raise ready -> valid low next cycle.
- clear at COMPUTE cycle 4 -> busy low next cycle, no result_valid. Then a new start of the box-blur case -> result=81 with no residue from the aborted run.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK convolution kernel engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        NORM,
        DONE
    } conv_state_t;

    // Worst-case signed MAC width: pixel*coef product plus growth over K*K terms.
    function automatic int acc_width(input int pix_w, input int coef_w, input int max_k);
        return pix_w + coef_w + 1 + $clog2(max_k * max_k);
    endfunction

    function automatic logic [63:0] clamp_pix(input logic signed [63:0] s, input int pix_w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< pix_w) - 64'sd1;
        if (s < 0) begin
            return '0;
        end else if (s > hi) begin
            return hi;
        end
        return s;
    endfunction

endpackage

// File: rtl/conv_raster_counter.sv
// Raster x/y position counter over a programmable KxK window, x inner, y outer.
module conv_raster_counter #(
    parameter  int MAX_K = 5,
    localparam int CW    = $clog2(MAX_K + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] k_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          last_o
);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [CW-1:0] k_last;

    assign k_last = k_i - CW'(1);
    assign last_o = (x_q == k_last) && (y_q == k_last);
    assign x_o    = x_q;
    assign y_o    = y_q;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_q == k_last) begin
                x_d = '0;
                y_d = y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/conv_kernel_engine.sv
// One-pixel KxK weighted-sum engine: serial MAC, arithmetic shift, optional |x|, saturate to a pixel.
module conv_kernel_engine
    import conv_pkg::*;
#(
    parameter  int MAX_KERNEL = 5,
    parameter  int PIX_W      = 8,
    parameter  int COEF_W     = 8,
    localparam int ACC_W      = acc_width(PIX_W, COEF_W, MAX_KERNEL),
    localparam int KW         = $clog2(MAX_KERNEL + 1),
    localparam int SW         = $clog2(ACC_W)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic [KW-1:0]            kernel_size,
    input  logic [SW-1:0]            norm_shift,
    input  logic                     abs_mode,
    input  logic [PIX_W-1:0]         input_matrix [MAX_KERNEL][MAX_KERNEL],
    input  logic signed [COEF_W-1:0] kernel       [MAX_KERNEL][MAX_KERNEL],
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [PIX_W-1:0]         result,
    output logic signed [ACC_W-1:0]  raw_sum,
    output logic                     saturated
);

    conv_state_t             state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [SW-1:0]           shift_q, shift_d;
    logic                    abs_q, abs_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] raw_q, raw_d;
    logic [PIX_W-1:0]        res_q, res_d;
    logic                    sat_q, sat_d;

    logic [PIX_W-1:0]         pix_q  [MAX_KERNEL][MAX_KERNEL];
    logic signed [COEF_W-1:0] coef_q [MAX_KERNEL][MAX_KERNEL];
    logic                     snap;

    logic [KW-1:0]           k_clamped;
    logic                    cnt_load, cnt_en, cnt_last;
    logic [KW-1:0]           cnt_x, cnt_y;
    logic signed [PIX_W:0]   pix_s;
    logic signed [ACC_W-1:0] prod, shifted, mag;
    logic [63:0]             clipped;

    assign k_clamped = (kernel_size > KW'(MAX_KERNEL)) ? KW'(MAX_KERNEL) : kernel_size;

    conv_raster_counter #(.MAX_K(MAX_KERNEL)) u_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .k_i    (k_q),
        .x_o    (cnt_x),
        .y_o    (cnt_y),
        .last_o (cnt_last)
    );

    // Pixels are unsigned, so they enter the signed product with a zero sign bit.
    assign pix_s   = signed'({1'b0, pix_q[cnt_y][cnt_x]});
    assign prod    = ACC_W'(pix_s) * ACC_W'(coef_q[cnt_y][cnt_x]);
    assign shifted = acc_q >>> shift_q;
    assign mag     = (abs_q && shifted < 0) ? -shifted : shifted;
    assign clipped = clamp_pix(64'(mag), PIX_W);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shift_d  = shift_q;
        abs_d    = abs_q;
        acc_d    = acc_q;
        raw_d    = raw_q;
        res_d    = res_q;
        sat_d    = sat_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        snap     = 1'b0;
        if (clear) begin
            // Abort keeps the last published result; only the operation in flight is dropped.
            state_d  = IDLE;
            acc_d    = '0;
            cnt_load = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap     = 1'b1;
                        k_d      = k_clamped;
                        shift_d  = norm_shift;
                        abs_d    = abs_mode;
                        acc_d    = '0;
                        cnt_load = 1'b1;
                        state_d  = (k_clamped == '0) ? NORM : COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc_d  = acc_q + prod;
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_d = NORM;
                    end
                end
                NORM: begin
                    res_d   = clipped[PIX_W-1:0];
                    sat_d   = (clipped != 64'(mag));
                    raw_d   = acc_q;
                    state_d = DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            shift_q <= '0;
            abs_q   <= 1'b0;
            acc_q   <= '0;
            raw_q   <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            shift_q <= shift_d;
            abs_q   <= abs_d;
            acc_q   <= acc_d;
            raw_q   <= raw_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
        end
    end

    // NOTE: the window snapshot is plain storage with no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (snap) begin
            pix_q  <= input_matrix;
            coef_q <= kernel;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = res_q;
    assign raw_sum      = raw_q;
    assign saturated    = sat_q;

endmodule

// File: tb/tb_conv_kernel_engine.sv
// Scoreboard bench for conv_kernel_engine: test-plan cases, handshake hold, abort and random windows.
module tb_conv_kernel_engine;
    import conv_pkg::*;

    localparam int MK = 5;
    localparam int PW = 8;
    localparam int CF = 8;
    localparam int AW = acc_width(PW, CF, MK);
    localparam int KW = $clog2(MK + 1);
    localparam int SW = $clog2(AW);

    typedef struct {
        longint res;
        longint raw;
        longint sat;
        longint lat;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  n_rst = 1'b0;
    logic                  start = 1'b0;
    logic                  clear = 1'b0;
    logic [KW-1:0]         kernel_size = '0;
    logic [SW-1:0]         norm_shift = '0;
    logic                  abs_mode = 1'b0;
    logic [PW-1:0]         input_matrix [MK][MK];
    logic signed [CF-1:0]  kernel       [MK][MK];
    logic                  busy;
    logic                  result_valid;
    logic                  result_ready = 1'b1;
    logic [PW-1:0]         result;
    logic signed [AW-1:0]  raw_sum;
    logic                  saturated;

    logic [PW-1:0]         pix  [MK][MK];
    logic signed [CF-1:0]  coef [MK][MK];
    exp_t                  sb_q [$];
    exp_t                  last_exp;
    int                    n_tests = 0;
    int                    n_fail  = 0;

    conv_kernel_engine #(.MAX_KERNEL(MK), .PIX_W(PW), .COEF_W(CF)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .clear        (clear),
        .kernel_size  (kernel_size),
        .norm_shift   (norm_shift),
        .abs_mode     (abs_mode),
        .input_matrix (input_matrix),
        .kernel       (kernel),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .raw_sum      (raw_sum),
        .saturated    (saturated)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int pv, input int cv);
        for (int y = 0; y < MK; y++)
            for (int x = 0; x < MK; x++) begin
                pix[y][x]  = PW'(pv);
                coef[y][x] = CF'(cv);
            end
    endtask

    task automatic set_sobel(input bit swapped);
        fill(0, 0);
        for (int y = 0; y < 3; y++) begin
            pix[y][0]  = swapped ? 8'd200 : 8'd10;
            pix[y][1]  = 8'd77;
            pix[y][2]  = swapped ? 8'd10 : 8'd200;
            coef[y][0] = (y == 1) ? -8'sd2 : -8'sd1;
            coef[y][2] = (y == 1) ? 8'sd2 : 8'sd1;
        end
    endtask

    task automatic drive_inputs(input int k, input int sh, input bit ab);
        for (int y = 0; y < MK; y++)
            for (int x = 0; x < MK; x++) begin
                input_matrix[y][x] = pix[y][x];
                kernel[y][x]       = coef[y][x];
            end
        kernel_size = KW'(k);
        norm_shift  = SW'(sh);
        abs_mode    = ab;
    endtask

    task automatic scramble_inputs();
        for (int y = 0; y < MK; y++)
            for (int x = 0; x < MK; x++) begin
                input_matrix[y][x] = PW'($urandom);
                kernel[y][x]       = CF'($urandom);
            end
        norm_shift = SW'($urandom);
        abs_mode   = ~abs_mode;
    endtask

    // Independent arithmetic model of one operation on the current pix/coef window.
    function automatic exp_t model(input int k, input int sh, input bit ab);
        exp_t   e;
        longint sum = 0;
        longint s;
        int     ke = (k > MK) ? MK : k;
        for (int y = 0; y < ke; y++)
            for (int x = 0; x < ke; x++)
                sum += longint'(pix[y][x]) * longint'(coef[y][x]);
        s = sum >>> sh;
        if (ab && s < 0) s = -s;
        e.raw = sum;
        e.lat = ke * ke + 2;
        if (s < 0)        begin e.res = 0;   e.sat = 1; end
        else if (s > 255) begin e.res = 255; e.sat = 1; end
        else              begin e.res = s;   e.sat = 0; end
        return e;
    endfunction

    function automatic exp_t mk_exp(input longint res, input longint raw, input longint sat, input longint lat);
        exp_t e;
        e.res = res; e.raw = raw; e.sat = sat; e.lat = lat;
        return e;
    endfunction

    // Latency is the index of the first posedge (start-sampling edge = 0) that sees result_valid high.
    task automatic run_op(input string tag, input int k, input int sh, input bit ab, input exp_t e, input bit hold);
        exp_t got_e;
        int   edges;
        sb_q.push_back(e);
        @(negedge clk);
        drive_inputs(k, sh, ab);
        result_ready = !hold;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        scramble_inputs();
        edges = 0;
        while (!result_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        got_e = sb_q.pop_front();
        check({tag, ".lat"}, edges + 1, got_e.lat);
        check({tag, ".result"}, result, got_e.res);
        check({tag, ".raw_sum"}, raw_sum, got_e.raw);
        check({tag, ".sat"}, saturated, got_e.sat);
        last_exp = got_e;
        if (!hold) begin
            @(negedge clk);
            check({tag, ".valid_drop"}, result_valid, 0);
        end
    endtask

    initial begin
        exp_t e;
        bit   seen;
        fill(0, 0);
        drive_inputs(0, 0, 0);

        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.valid", result_valid, 0);
        check("rst.result", result, 0);
        check("rst.raw_sum", raw_sum, 0);
        check("rst.sat", saturated, 0);
        n_rst = 1'b1;

        fill(9, 1);
        run_op("box", 3, 0, 0, mk_exp(81, 81, 0, 11), 0);

        set_sobel(0);
        run_op("sobel_abs_sh2", 3, 2, 1, mk_exp(190, 760, 0, 11), 0);
        run_op("sobel_sh0", 3, 0, 1, mk_exp(255, 760, 1, 11), 0);
        set_sobel(1);
        run_op("sobel_neg", 3, 0, 0, mk_exp(0, -760, 1, 11), 0);

        fill(0, 0);
        pix[0][0]  = 8'd100;
        coef[0][0] = -8'sd3;
        run_op("k1_abs", 1, 0, 1, mk_exp(255, -300, 1, 3), 0);

        fill(40, 5);
        run_op("k0", 0, 0, 0, mk_exp(0, 0, 0, 2), 0);

        fill(1, 1);
        run_op("k7_clamped", 7, 0, 0, mk_exp(25, 25, 0, 27), 0);

        fill(255, 127);
        run_op("full_5x5", 5, 12, 0, mk_exp(197, 809625, 0, 27), 0);

        // Consumer stalls in DONE; start pulses must not disturb the held result.
        fill(9, 1);
        run_op("hold", 3, 0, 0, mk_exp(81, 81, 0, 11), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            check("hold.valid", result_valid, 1);
            check("hold.result", result, last_exp.res);
            check("hold.raw_sum", raw_sum, last_exp.raw);
            check("hold.sat", saturated, last_exp.sat);
        end
        @(negedge clk);
        result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold.valid_drop", result_valid, 0);
        check("hold.busy_drop", busy, 0);
        @(negedge clk);
        check("hold.start_ignored", busy, 0);

        // Abort mid-COMPUTE with a window that would give a different result.
        fill(50, 3);
        @(negedge clk);
        drive_inputs(3, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr.busy", busy, 0);
        check("clr.raw_kept", raw_sum, last_exp.raw);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid || busy) seen = 1'b1;
        end
        check("clr.idle", seen, 0);
        fill(9, 1);
        run_op("box_after_clr", 3, 0, 0, mk_exp(81, 81, 0, 11), 0);

        for (int r = 0; r < 5; r++) begin
            int k, sh;
            bit ab;
            k  = $urandom_range(1, 5);
            sh = $urandom_range(0, 10);
            ab = 1'($urandom_range(0, 1));
            for (int y = 0; y < MK; y++)
                for (int x = 0; x < MK; x++) begin
                    pix[y][x]  = PW'($urandom);
                    coef[y][x] = CF'($urandom);
                end
            e = model(k, sh, ab);
            run_op($sformatf("rand%0d", r), k, sh, ab, e, 0);
        end

        // Reset in the middle of an operation.
        fill(9, 1);
        @(negedge clk);
        drive_inputs(3, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        check("midrst.busy", busy, 0);
        check("midrst.valid", result_valid, 0);
        check("midrst.result", result, 0);
        check("midrst.raw_sum", raw_sum, 0);
        check("midrst.sat", saturated, 0);
        check("sb.empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
